sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-port arbiter that shares the single SRAM controller between the data-side cache controller (port D) and an instruction-fetch miss path (port I). It sits between the requesters and the SRAM controller, locks a grant for a whole access, and forwards that access's read data and completion. Port D has fixed priority, and a starvation counter bounds how long port I can wait.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width on all ports
STARVE_LIMIT, 4, consecutive port-D grants after which a waiting port I wins the next arbitration (must be >=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
d_rd  input  1  port D read request, held until d_ready
d_wr  input  1  port D write request, held until d_ready
d_addr  input  ADDR_W  port D address
d_wdata  input  DATA_W  port D write data
d_rdata  output  DATA_W  port D read data, valid when d_ready=1 and the access was a read
d_ready  output  1  port D completion/idle indicator
i_rd  input  1  port I read request (read-only port)
i_addr  input  ADDR_W  port I address
i_rdata  output  DATA_W  port I read data
i_ready  output  1  port I completion/idle indicator
mem_read  output  1  read request to SRAM controller
mem_write  output  1  write request to SRAM controller
mem_addr  output  ADDR_W  address to SRAM controller
mem_wdata  output  DATA_W  write data to SRAM controller
mem_rdata  input  DATA_W  read data from SRAM controller
mem_ready  input  1  controller ready; low while busy, high on the final cycle of an access

Behaviour:
- Downstream contract: the arbiter holds mem_read/mem_write/mem_addr/mem_wdata stable until the cycle where the request is asserted and mem_ready=1. That cycle is completion.
- FSM states: IDLE, BUSY_D, BUSY_I. State and grant are registered; mem_* outputs are decoded from state only.
- IDLE:
  - mem_read=mem_write=0; mem_addr/mem_wdata=0.
  - Arbitration is sampled from the current request inputs.
  - If port D requests and (port I is not requesting or starve_cnt<STARVE_LIMIT): go to BUSY_D.
  - Else if i_rd: go to BUSY_I.
  - Else stay in IDLE.
- BUSY_D:
  - mem_read=d_rd&~d_wr, mem_write=d_wr, mem_addr=d_addr, mem_wdata=d_wdata.
  - On completion: go to IDLE.
  - If d_rd=d_wr=0 (requester abort): go to IDLE next cycle; the downstream request drops combinationally in that cycle.
- BUSY_I:
  - mem_read=i_rd, mem_write=0, mem_addr=i_addr, mem_wdata=0.
  - Completion and abort rules are the same as BUSY_D.
- First-access latency: a request seen in IDLE at cycle t is presented downstream from cycle t+1.
- Back-to-back accesses always pass through one IDLE cycle.
- Requester ready signals:
  - d_ready = (state==BUSY_D) ? mem_ready : ~(d_rd|d_wr).
  - i_ready = (state==BUSY_I) ? mem_ready : ~i_rd.
  - A requesting but ungranted port sees ready=0, so that stage freezes.
- Read data: d_rdata=mem_rdata when state==BUSY_D, else 0. i_rdata=mem_rdata when state==BUSY_I, else 0.
- Simultaneous d_rd and d_wr: treated as a write.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - Increments, saturating at STARVE_LIMIT, on each IDLE->BUSY_D transition taken while i_rd=1.
  - Clears on IDLE->BUSY_I.
  - Also clears in any IDLE cycle with i_rd=0.
- Reset, including mid-access:
  - Next state IDLE, starve_cnt=0; mem_read=mem_write=0 from the first cycle after rst is sampled.
  - d_ready=~(d_rd|d_wr), i_ready=~i_rd, rdata outputs 0.
  - An in-flight access is abandoned. The SRAM controller is reset by the same rst.
- Port D request and completion in the same cycle cannot occur in IDLE, because completion only exists in BUSY states.

Test Plan:
1. Reset with d_rd=1, i_rd=1 held -> during rst and the next IDLE cycle mem_read=0, d_ready=0, i_ready=0, starve_cnt=0; one cycle after rst deasserts, state=BUSY_D and mem_addr=d_addr.
2. Single port-D read of addr 0x40, controller ready after 5 cycles with mem_rdata=0xDEADBEEF -> mem_read high for exactly those cycles; d_ready=1 and d_rdata=0xDEADBEEF on the completion cycle only; one IDLE cycle follows.
3. Port-D write addr 0x80 data 0x12345678 -> mem_write=1, mem_read=0, mem_wdata=0x12345678 held until mem_ready; i_ready stays 1 with i_rd=0.
4. Both ports request continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; i_rdata is nonzero only on I completion cycles.
5. Port I granted at addr 0x100, then d_wr rises mid-access -> I access completes uninterrupted; d_ready=0 throughout; D is granted after the intervening IDLE cycle.
6. rst asserted in the middle of a BUSY_D read (mem_ready=0) -> the cycle after, mem_read=0, state IDLE, d_rdata=0; the request is re-arbitrated after rst deasserts.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter
// ------------
// Shares one SRAM controller between the data-side cache controller
// (port D) and the instruction-fetch miss path (port I). One requester is
// granted per access, and the grant is held until that access completes or
// is abandoned. Port D has fixed priority. A starvation counter lets a
// waiting port I win after STARVE_LIMIT consecutive port-D grants.
//
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   d_rd, d_wr, d_addr, d_wdata   port D request (read/write), held until d_ready
//   d_rdata, d_ready              port D read data / completion-or-idle
//   i_rd, i_addr                  port I read request, held until i_ready
//   i_rdata, i_ready              port I read data / completion-or-idle
//   mem_read, mem_write           request to the SRAM controller
//   mem_addr, mem_wdata           address / write data to the SRAM controller
//   mem_rdata, mem_ready          read data / final-cycle indicator from controller
module sram_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] starve_cnt_reg;

    logic d_req;
    logic d_wins;

    assign d_req  = d_rd | d_wr;
    // Port D keeps priority unless port I is waiting and has already been
    // passed over STARVE_LIMIT times in a row.
    assign d_wins = d_req && (!i_rd || (starve_cnt_reg < LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (d_wins) begin
                        state_reg <= BUSY_D;
                        // Only a grant that made port I wait counts toward starvation.
                        if (i_rd) begin
                            if (starve_cnt_reg != LIMIT)
                                starve_cnt_reg <= starve_cnt_reg + 1'b1;
                        end else begin
                            starve_cnt_reg <= '0;
                        end
                    end else if (i_rd) begin
                        state_reg      <= BUSY_I;
                        starve_cnt_reg <= '0;
                    end else begin
                        starve_cnt_reg <= '0;
                    end
                end
                BUSY_D: begin
                    // Completion or requester abort both end the access.
                    if (!d_req || mem_ready)
                        state_reg <= IDLE;
                end
                BUSY_I: begin
                    if (!i_rd || mem_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Downstream request is decoded from the grant; request lines follow the
    // granted requester directly so an abort drops them in the same cycle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        d_rdata   = '0;
        i_rdata   = '0;
        d_ready   = ~d_req;
        i_ready   = ~i_rd;
        case (state_reg)
            BUSY_D: begin
                // Simultaneous read and write is treated as a write.
                mem_read  = d_rd & ~d_wr;
                mem_write = d_wr;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_rdata   = mem_rdata;
                d_ready   = mem_ready;
            end
            BUSY_I: begin
                mem_read  = i_rd;
                mem_addr  = i_addr;
                i_rdata   = mem_rdata;
                i_ready   = mem_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              d_rd, d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              i_rd;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; d_rd = 1'b1; d_wr = 1'b0; d_addr = 32'h10; d_wdata = '0;
        i_rd = 1'b1; i_addr = 32'h20; mem_rdata = '0; mem_ready = 1'b0;

        // 1. Reset with both ports requesting
        tick();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_i_ready", i_ready, 0);
        tick();
        rst = 1'b0; #1;
        chk("post_rst_idle_mem_read", mem_read, 0);
        chk("post_rst_idle_d_ready", d_ready, 0);
        tick();
        chk("post_rst_grant_d_addr", mem_addr, 32'h10);
        chk("post_rst_grant_d_read", mem_read, 1);
        chk("post_rst_i_ready", i_ready, 0);
        mem_ready = 1'b1; #1;
        chk("post_rst_d_ready", d_ready, 1);
        tick();
        d_rd = 1'b0; i_rd = 1'b0; mem_ready = 1'b0; #1;
        chk("post_rst_back_idle", mem_read, 0);
        $display("txn reset: D granted first after rst");

        // 2. Port D read 0x40, controller ready on the 5th busy cycle
        d_rd = 1'b1; d_addr = 32'h40; #1;
        chk("rd_idle_no_req_yet", mem_read, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            mem_ready = (k == 4);
            mem_rdata = (k == 4) ? 32'hDEADBEEF : 32'h0;
            #1;
            chk("rd_mem_read", mem_read, 1);
            chk("rd_mem_addr", mem_addr, 32'h40);
            chk("rd_d_ready", d_ready, (k == 4) ? 32'd1 : 32'd0);
            chk("rd_d_rdata", d_rdata, (k == 4) ? 32'hDEADBEEF : 32'h0);
            tick();
        end
        d_rd = 1'b0; mem_ready = 1'b0; #1;
        chk("rd_after_idle_read", mem_read, 0);
        chk("rd_after_rdata_gated", d_rdata, 0);
        chk("rd_after_d_ready", d_ready, 1);
        $display("txn D read addr=0x40 data=%h", 32'hDEADBEEF);

        // 3. Port D write 0x80
        d_wr = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678; mem_rdata = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 2);
            #1;
            chk("wr_mem_write", mem_write, 1);
            chk("wr_mem_read", mem_read, 0);
            chk("wr_mem_wdata", mem_wdata, 32'h12345678);
            chk("wr_i_ready", i_ready, 1);
            tick();
        end
        d_wr = 1'b0; d_wdata = '0; mem_ready = 1'b0; #1;
        chk("wr_after_idle", mem_write, 0);
        $display("txn D write addr=0x80 data=%h", 32'h12345678);

        // 4. Continuous contention: D,D,D,D,I,D,D,D,D,I
        d_rd = 1'b1; d_addr = 32'hD00; i_rd = 1'b1; i_addr = 32'hA00;
        for (int g = 0; g < 10; g++) begin
            logic exp_i;
            exp_i = (g == 4) || (g == 9);
            tick();
            mem_ready = 1'b1; mem_rdata = 32'hA5A50000 + 32'(g); #1;
            chk("arb_grant_addr", mem_addr, exp_i ? 32'hA00 : 32'hD00);
            chk("arb_i_rdata", i_rdata, exp_i ? (32'hA5A50000 + 32'(g)) : 32'h0);
            chk("arb_d_ready", d_ready, exp_i ? 32'd0 : 32'd1);
            $display("txn arb grant %0d -> %s", g, (mem_addr == 32'hA00) ? "I" : "D");
            tick();
            mem_ready = 1'b0; #1;
            chk("arb_idle_i_rdata", i_rdata, 0);
        end

        // 5. Port I access at 0x100, D write arrives mid-access
        d_rd = 1'b0; i_addr = 32'h100; mem_rdata = '0;
        tick();
        chk("i_grant_addr", mem_addr, 32'h100);
        d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFE0001; #1;
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 2);
            mem_rdata = (k == 2) ? 32'h0BADF00D : 32'h0;
            #1;
            chk("i_mid_addr", mem_addr, 32'h100);
            chk("i_mid_no_write", mem_write, 0);
            chk("i_mid_d_ready", d_ready, 0);
            tick();
        end
        i_rd = 1'b0; mem_ready = 1'b0; #1;
        chk("i_then_idle_write", mem_write, 0);
        chk("i_then_idle_d_ready", d_ready, 0);
        tick();
        chk("d_after_i_write", mem_write, 1);
        chk("d_after_i_addr", mem_addr, 32'h200);
        mem_ready = 1'b1;
        tick();
        d_wr = 1'b0; mem_ready = 1'b0; #1;
        $display("txn I read addr=0x100 then D write addr=0x200");

        // 6. Reset in the middle of a port D read, then abort
        d_rd = 1'b1; d_addr = 32'h300;
        tick();
        mem_rdata = 32'h00000055; #1;
        chk("rst_mid_busy_read", mem_read, 1);
        chk("rst_mid_busy_rdata", d_rdata, 32'h55);
        rst = 1'b1;
        tick();
        chk("rst_mid_read_drop", mem_read, 0);
        chk("rst_mid_rdata_zero", d_rdata, 0);
        chk("rst_mid_d_ready", d_ready, 0);
        rst = 1'b0;
        tick();
        chk("rst_mid_rearb_addr", mem_addr, 32'h300);
        chk("rst_mid_rearb_read", mem_read, 1);
        d_rd = 1'b0; #1;
        chk("abort_read_drop", mem_read, 0);
        chk("abort_d_ready", d_ready, 0);
        tick();
        chk("abort_idle_d_ready", d_ready, 1);
        $display("txn reset mid-access addr=0x300 then abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
